// File: rtl/posit_adder_scheduler.sv
// Round-robin scheduler sharing one combinational posit adder between NUM_REQ requesters.
// Two registered stages: issue (drives adder operands) and response (captures adder result).
module posit_adder_scheduler #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned PD_IN_W  = 16,
  parameter int unsigned PD_OUT_W = 22,
  parameter int unsigned TAG_W    = 4,
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*PD_IN_W-1:0]  req_op1,
  input  logic [NUM_REQ*PD_IN_W-1:0]  req_op2,
  input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
  output logic [PD_IN_W-1:0]          add_op1,
  output logic [PD_IN_W-1:0]          add_op2,
  input  logic [PD_OUT_W-1:0]         add_res,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [PD_OUT_W-1:0]         resp_data,
  output logic [ID_W-1:0]             resp_id,
  output logic [TAG_W-1:0]            resp_tag,
  output logic                        busy
);

  logic              s1_valid;
  logic [TAG_W-1:0]  s1_tag;
  logic [ID_W-1:0]   s1_id;
  logic [ID_W-1:0]   rr_ptr;

  logic              s2_adv;
  logic              s1_adv;
  logic              grant_en;
  logic              grant;
  logic              win_found;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   cand_id;
  int unsigned       idx;

  assign s2_adv   = !resp_valid || resp_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign grant_en = enable && (!s1_valid || s2_adv);

  // Search starts one past the last winner, so the last winner has lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    cand_id   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx     = (32'(rr_ptr) + k) % NUM_REQ;
      cand_id = ID_W'(idx);
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_id    = cand_id;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_en && win_found && !rst) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign grant = |req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      add_op1  <= '0;
      add_op2  <= '0;
      s1_tag   <= '0;
      s1_id    <= '0;
      rr_ptr   <= ID_W'(NUM_REQ - 1);
    end else if (grant) begin
      s1_valid <= 1'b1;
      add_op1  <= req_op1[win_id*PD_IN_W +: PD_IN_W];
      add_op2  <= req_op2[win_id*PD_IN_W +: PD_IN_W];
      s1_tag   <= req_tag[win_id*TAG_W +: TAG_W];
      s1_id    <= win_id;
      rr_ptr   <= win_id;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_id    <= '0;
      resp_tag   <= '0;
    end else if (s1_adv) begin
      resp_valid <= 1'b1;
      resp_data  <= add_res;
      resp_id    <= s1_id;
      resp_tag   <= s1_tag;
    end else if (resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  assign busy = s1_valid || resp_valid;

  // Requesters must keep operands and tag stable while waiting for a grant.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stable_chk
    assert property (@(posedge clk) disable iff (rst)
      (req_valid[i] && !req_ready[i]) |=>
        (!req_valid[i] || ($stable(req_op1[i*PD_IN_W +: PD_IN_W]) &&
                           $stable(req_op2[i*PD_IN_W +: PD_IN_W]) &&
                           $stable(req_tag[i*TAG_W +: TAG_W]))));
  end

endmodule

// File: tb/tb_posit_adder_scheduler.sv
// Directed self-checking bench for posit_adder_scheduler with a stand-in adder.
module tb_posit_adder_scheduler;

  localparam int unsigned NUM_REQ  = 4;
  localparam int unsigned PD_IN_W  = 16;
  localparam int unsigned PD_OUT_W = 22;
  localparam int unsigned TAG_W    = 4;
  localparam int unsigned ID_W     = 2;

  logic                       clk;
  logic                       rst;
  logic                       enable;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*PD_IN_W-1:0] req_op1;
  logic [NUM_REQ*PD_IN_W-1:0] req_op2;
  logic [NUM_REQ*TAG_W-1:0]   req_tag;
  logic [PD_IN_W-1:0]         add_op1;
  logic [PD_IN_W-1:0]         add_op2;
  logic [PD_OUT_W-1:0]        add_res;
  logic                       resp_valid;
  logic                       resp_ready;
  logic [PD_OUT_W-1:0]        resp_data;
  logic [ID_W-1:0]            resp_id;
  logic [TAG_W-1:0]           resp_tag;
  logic                       busy;

  int total;
  int bad;

  function automatic logic [15:0] op1_of(int i);
    return 16'h1234 + 16'(i) * 16'h0101;
  endfunction

  function automatic logic [15:0] op2_of(int i);
    return 16'h0F0F ^ (16'(i) * 16'h1111);
  endfunction

  function automatic logic [3:0] tag_of(int i);
    return 4'(i + 3);
  endfunction

  // Asymmetric stand-in for the adder so swapped operands are visible.
  function automatic logic [21:0] fake_add(logic [15:0] a, logic [15:0] b);
    return {a[15:10] ^ b[5:0], a - b};
  endfunction

  assign add_res = fake_add(add_op1, add_op2);

  posit_adder_scheduler #(
    .NUM_REQ (NUM_REQ),
    .PD_IN_W (PD_IN_W),
    .PD_OUT_W(PD_OUT_W),
    .TAG_W   (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op1   (req_op1),
    .req_op2   (req_op2),
    .req_tag   (req_tag),
    .add_op1   (add_op1),
    .add_op2   (add_op2),
    .add_res   (add_res),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .resp_tag  (resp_tag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    req_valid = '0;
    enable = 1'b1;
    resp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_resp(string name, int id);
    total++;
    if (resp_valid !== 1'b1 || resp_id !== ID_W'(id) || resp_tag !== tag_of(id) ||
        resp_data !== fake_add(op1_of(id), op2_of(id))) begin
      bad++;
      $display("FAIL %s got v=%b id=%0d tag=%0d data=%h exp v=1 id=%0d tag=%0d data=%h",
               name, resp_valid, resp_id, resp_tag, resp_data, id, tag_of(id),
               fake_add(op1_of(id), op2_of(id)));
    end
  endtask

  task automatic test_reset();
    step();
    rst = 1'b1;
    req_valid = '1;
    #1;
    total++;
    if (req_ready !== 4'b0000 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got ready=%b rv=%b busy=%b exp 0000/0/0",
               req_ready, resp_valid, busy);
    end
    total++;
    if (add_op1 !== '0 || add_op2 !== '0 || resp_data !== '0 || resp_id !== '0 ||
        resp_tag !== '0) begin
      bad++;
      $display("FAIL reset_data got op1=%h op2=%h data=%h id=%0d tag=%0d exp all 0",
               add_op1, add_op2, resp_data, resp_id, resp_tag);
    end
    step();
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_hold_ready got=%b exp=0000", req_ready);
    end
    rst = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    step();
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    step();
    req_valid = '0;
    #1;
    total++;
    if (resp_valid !== 1'b0 || add_op1 !== op1_of(0) || add_op2 !== op2_of(0)) begin
      bad++;
      $display("FAIL single_issue got rv=%b op1=%h op2=%h exp rv=0 op1=%h op2=%h",
               resp_valid, add_op1, add_op2, op1_of(0), op2_of(0));
    end
    step();
    #1;
    check_resp("single_resp", 0);
    step();
    #1;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL single_idle got rv=%b busy=%b exp 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step();
      req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      #1;
      exp_ready = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      total++;
      if (req_ready !== exp_ready) begin
        bad++;
        $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_ready);
      end
      if (k >= 2) check_resp($sformatf("rr_resp[%0d]", k), (k - 2) % 4);
    end
    step();
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rr_drain got rv=%b exp=0", resp_valid);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_ready;
    do_reset();
    step();
    req_valid = 4'b1000;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin
      bad++;
      $display("FAIL wrap_first got=%b exp=1000", req_ready);
    end
    for (int j = 0; j < 3; j++) begin
      step();
      req_valid = 4'b1010;
      #1;
      exp_ready = (j % 2 == 0) ? 4'b0010 : 4'b1000;
      total++;
      if (req_ready !== exp_ready) begin
        bad++;
        $display("FAIL wrap_ready[%0d] got=%b exp=%b", j, req_ready, exp_ready);
      end
      if (j == 1) check_resp("wrap_resp3", 3);
      if (j == 2) check_resp("wrap_resp1", 1);
    end
    step();
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_ready;
    int accepts;
    accepts = 0;
    do_reset();
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      req_valid = 4'b1111;
      #1;
      if (req_ready != 4'b0000) accepts++;
      exp_ready = (c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000;
      total++;
      if (req_ready !== exp_ready) begin
        bad++;
        $display("FAIL bp_ready[%0d] got=%b exp=%b", c, req_ready, exp_ready);
      end
      if (c >= 2) check_resp($sformatf("bp_hold[%0d]", c), 0);
    end
    total++;
    if (accepts != 2) begin
      bad++;
      $display("FAIL bp_accepts got=%0d exp=2", accepts);
    end
    step();
    resp_ready = 1'b1;
    req_valid = '0;
    #1;
    check_resp("bp_drain0", 0);
    step();
    #1;
    check_resp("bp_drain1", 1);
    step();
    #1;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty got rv=%b busy=%b exp 0/0", resp_valid, busy);
    end
  endtask

  task automatic test_enable();
    do_reset();
    resp_ready = 1'b0;
    step();
    req_valid = 4'b0011;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL en_grant0 got=%b exp=0001", req_ready);
    end
    step();
    #1;
    total++;
    if (req_ready !== 4'b0010) begin
      bad++;
      $display("FAIL en_grant1 got=%b exp=0010", req_ready);
    end
    step();
    enable = 1'b0;
    resp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL en_off_ready0 got=%b exp=0000", req_ready);
    end
    check_resp("en_resp0", 0);
    step();
    #1;
    total++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      bad++;
      $display("FAIL en_off_ready1 got ready=%b busy=%b exp 0000/1", req_ready, busy);
    end
    check_resp("en_resp1", 1);
    step();
    #1;
    total++;
    if (req_ready !== 4'b0000 || busy !== 1'b0 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL en_drained got ready=%b busy=%b rv=%b exp 0000/0/0",
               req_ready, busy, resp_valid);
    end
    step();
    enable = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL en_resume got=%b exp=0100", req_ready);
    end
    step();
    req_valid = '0;
    repeat (3) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    resp_ready = 1'b0;
    step();
    req_valid = 4'b1111;
    step();
    step();
    #1;
    total++;
    if (busy !== 1'b1 || resp_valid !== 1'b1) begin
      bad++;
      $display("FAIL rmid_full got busy=%b rv=%b exp 1/1", busy, resp_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0000 || add_op1 !== '0) begin
      bad++;
      $display("FAIL rmid_async got rv=%b busy=%b ready=%b op1=%h exp 0/0/0000/0",
               resp_valid, busy, req_ready, add_op1);
    end
    step();
    step();
    rst = 1'b0;
    resp_ready = 1'b1;
    #1;
    total++;
    if (req_ready !== 4'b0001 || resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_first got ready=%b rv=%b exp 0001/0", req_ready, resp_valid);
    end
    step();
    req_valid = '0;
    #1;
    total++;
    if (resp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_stale got rv=%b exp=0", resp_valid);
    end
    step();
    #1;
    check_resp("rmid_resp", 0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    enable = 1'b1;
    req_valid = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_op1[i*PD_IN_W +: PD_IN_W] = op1_of(i);
      req_op2[i*PD_IN_W +: PD_IN_W] = op2_of(i);
      req_tag[i*TAG_W +: TAG_W]     = tag_of(i);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_backpressure();
    test_enable();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
